// File: rtl/pipe_stage_hs_pkg.sv
// Shared constants for the generic pipeline stage register pipe_stage_hs.
// Holds the default payload widths, the per-boundary widths of the classic
// IF/ID, ID/EX, EX/MEM and MEM/WB instances, and the occupancy width helper.
// Optional feature macro: PIPE_SKID_EN (adds one skid entry per slot).
package pipe_stage_hs_pkg;

    // Default payload split: control bits are cleared on a bubble, data bits are not.
    localparam int PIPE_DEF_CTRL_W = 16;
    localparam int PIPE_DEF_DATA_W = 256;
    localparam int PIPE_DEF_DEPTH  = 1;

    // Pipeline boundaries that historically had their own fixed register block.
    typedef enum logic [1:0] {
        BND_IF_ID  = 2'd0,
        BND_ID_EX  = 2'd1,
        BND_EX_MEM = 2'd2,
        BND_MEM_WB = 2'd3
    } pipe_boundary_e;

    // Control-field width used at each boundary.
    function automatic int boundary_ctrl_w(input pipe_boundary_e bnd);
        int w;
        case (bnd)
            BND_IF_ID:  w = 2;
            BND_ID_EX:  w = 16;
            BND_EX_MEM: w = 8;
            BND_MEM_WB: w = 4;
            default:    w = PIPE_DEF_CTRL_W;
        endcase
        return w;
    endfunction

    // Data-field width used at each boundary.
    function automatic int boundary_data_w(input pipe_boundary_e bnd);
        int w;
        case (bnd)
            BND_IF_ID:  w = 64;
            BND_ID_EX:  w = 256;
            BND_EX_MEM: w = 160;
            BND_MEM_WB: w = 96;
            default:    w = PIPE_DEF_DATA_W;
        endcase
        return w;
    endfunction

    // Width of the occupancy counter: must hold 0..2*depth (skid capacity).
    function automatic int occ_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_hs_slot.sv
// One slot of pipe_stage_hs: valid bit, control and data registers and the
// local valid/ready handshake. Slots are chained by the top module.
// With PIPE_SKID_EN defined the slot carries a second (skid) entry and its
// upstream ready is taken straight from a flop, breaking the ready ripple.
module pipe_stage_hs_slot
    import pipe_stage_hs_pkg::*;
#(
    parameter int CTRL_W = PIPE_DEF_CTRL_W,
    parameter int DATA_W = PIPE_DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [CTRL_W-1:0] up_ctrl_i,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [CTRL_W-1:0] dn_ctrl_o,
    output logic [DATA_W-1:0] dn_data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              accept_s;

`ifdef PIPE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              main_free_s;

    // Next state of main and skid entries; the skid only fills while the main entry is stuck.
    always_comb begin
        up_ready_o   = ~skid_valid_q;
        accept_s     = up_valid_i & ~skid_valid_q;
        main_free_s  = ~valid_q | dn_ready_i;
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        data_d       = data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            valid_d      = 1'b0;
            ctrl_d       = {CTRL_W{1'b0}};
            skid_valid_d = 1'b0;
            skid_ctrl_d  = {CTRL_W{1'b0}};
        end else if (main_free_s) begin
            if (skid_valid_q) begin
                // Older skid entry moves up; no accept is possible while it is full.
                valid_d      = 1'b1;
                ctrl_d       = skid_ctrl_q;
                data_d       = skid_data_q;
                skid_valid_d = 1'b0;
                skid_ctrl_d  = {CTRL_W{1'b0}};
            end else if (accept_s) begin
                valid_d = 1'b1;
                ctrl_d  = up_ctrl_i;
                data_d  = up_data_i;
            end else begin
                valid_d = 1'b0;
                ctrl_d  = {CTRL_W{1'b0}};
            end
        end else if (accept_s) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = up_ctrl_i;
            skid_data_d  = up_data_i;
        end else begin
            skid_valid_d = skid_valid_q;
        end
    end

    // Skid entry registers; reset clears payload as well as the valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= {CTRL_W{1'b0}};
            skid_data_q  <= {DATA_W{1'b0}};
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    // Next state of the single entry; ready ripples combinationally from downstream.
    always_comb begin
        up_ready_o = ~valid_q | dn_ready_i;
        accept_s   = up_valid_i & up_ready_o;
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        data_d     = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = {CTRL_W{1'b0}};
        end else if (accept_s) begin
            valid_d = 1'b1;
            ctrl_d  = up_ctrl_i;
            data_d  = up_data_i;
        end else if (valid_q & dn_ready_i) begin
            valid_d = 1'b0;
            ctrl_d  = {CTRL_W{1'b0}};
        end else begin
            valid_d = valid_q;
        end
    end
`endif

    // Main entry registers; data only changes when a new entry is loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= {CTRL_W{1'b0}};
            data_q  <= {DATA_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign dn_valid_o = valid_q;
    assign dn_ctrl_o  = ctrl_q;
    assign dn_data_o  = data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Generic pipeline register: DEPTH chained slots with valid/ready handshake,
// backpressure stall and flush-to-bubble. Control payload is zeroed on a
// bubble, data payload is held. Optional macro PIPE_SKID_EN adds a skid
// entry per slot so in_ready comes from a flop (capacity 2*DEPTH).
module pipe_stage_hs
    import pipe_stage_hs_pkg::*;
#(
    parameter int CTRL_W = PIPE_DEF_CTRL_W,
    parameter int DATA_W = PIPE_DEF_DATA_W,
    parameter int DEPTH  = PIPE_DEF_DEPTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [CTRL_W-1:0]                in_ctrl,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CTRL_W-1:0]                out_ctrl,
    output logic [DATA_W-1:0]                out_data,
    output logic [$clog2(2*DEPTH+1)-1:0]     occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    // Chain index k is the upstream side of slot k; index DEPTH is the block output.
    logic [DEPTH:0]             chain_valid_s;
    logic [DEPTH:0]             chain_ready_s;
    logic [DEPTH:0][CTRL_W-1:0] chain_ctrl_s;
    logic [DEPTH:0][DATA_W-1:0] chain_data_s;

    logic             in_fire_s;
    logic             out_fire_s;
    logic [OCC_W-1:0] occ_q, occ_d;

    assign chain_valid_s[0]     = in_valid;
    assign chain_ctrl_s[0]      = in_ctrl;
    assign chain_data_s[0]      = in_data;
    assign chain_ready_s[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        pipe_stage_hs_slot #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .flush_i    (flush),
            .up_valid_i (chain_valid_s[k]),
            .up_ready_o (chain_ready_s[k]),
            .up_ctrl_i  (chain_ctrl_s[k]),
            .up_data_i  (chain_data_s[k]),
            .dn_valid_o (chain_valid_s[k+1]),
            .dn_ready_i (chain_ready_s[k+1]),
            .dn_ctrl_o  (chain_ctrl_s[k+1]),
            .dn_data_o  (chain_data_s[k+1])
        );
    end

    // Boundary handshake: flush blocks both sides for the cycle it is high.
    always_comb begin
        in_ready   = chain_ready_s[0] & ~flush;
        out_valid  = chain_valid_s[DEPTH] & ~flush;
        in_fire_s  = in_valid & in_ready;
        out_fire_s = out_valid & out_ready;
        if (out_valid) begin
            out_ctrl = chain_ctrl_s[DEPTH];
        end else begin
            out_ctrl = {CTRL_W{1'b0}};
        end
        out_data = chain_data_s[DEPTH];
    end

    // Occupancy next state: +1 per accept, -1 per emit, flush empties the chain.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = {OCC_W{1'b0}};
        end else begin
            case ({in_fire_s, out_fire_s})
                2'b10:   occ_d = occ_q + {{(OCC_W-1){1'b0}}, 1'b1};
                2'b01:   occ_d = occ_q - {{(OCC_W-1){1'b0}}, 1'b1};
                default: occ_d = occ_q;
            endcase
        end
    end

    // Occupancy counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= {OCC_W{1'b0}};
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule
